signed_result_decoder: RTL and testbench

Converts an 8-bit arithmetic-unit result (two's complement in signed mode, plain binary in unsigned mode) back into sign-magnitude form and three BCD digits for the calculator display path. It sits downstream of the subtractor and adder datapaths, which encode sign-magnitude operands into two's complement, and performs the reverse translation. The BCD conversion is sequential shift-add-3 (double-dabble), one bit per clock, with a start/busy/done handshake.

---
 rtl/signed_result_decoder.sv | 125 ++++++++++++
 tb/tb_signed_result_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/signed_result_decoder.sv
// signed_result_decoder
//   Turns an 8-bit arithmetic result into sign-magnitude and three BCD digits
//   for the calculator display. Signed results in two's complement are
//   negated back to a magnitude. Double-dabble (shift-add-3) then runs one
//   bit per clock.
//
//   Ports:
//     Clk, Rst      rising-edge clock, async active-high reset
//     Start         request a conversion (only sampled while idle)
//     Signed_Mode   1: Result is two's complement, 0: unsigned 0..255
//     Result        value to decode (captured on the accepting edge)
//     Sign          1 = negative (never set in unsigned mode)
//     Hundreds/Tens/Ones  BCD digits of the magnitude
//     Busy          conversion in progress (9 cycles)
//     Done          one-cycle pulse when the outputs update

// One BCD digit of the dabble correction: a digit of 5 or more gets +3
// before the shift, so it carries correctly into the next digit.
module signed_result_decoder_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
endmodule

module signed_result_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] Result,
    output logic             Sign,
    output logic [3:0]       Hundreds,
    output logic [3:0]       Tens,
    output logic [3:0]       Ones,
    output logic             Busy,
    output logic             Done
);
    localparam int DIGITS = 3;
    localparam int CNT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    state_t                      state_q, state_d;
    logic [WIDTH-1:0]            mag_q;
    logic [DIGITS-1:0][3:0]      scratch_q;
    logic [DIGITS-1:0][3:0]      adj;
    logic [CNT_W-1:0]            cnt_q;
    logic                        sign_pend_q;
    logic                        neg_in;
    logic [WIDTH-1:0]            mag_in;
    logic [4*DIGITS+WIDTH-1:0]   shifted;

    // Negating 0x80 wraps back to 0x80. Read as unsigned, that is 128, so
    // the most negative value needs no special case.
    assign neg_in = Signed_Mode & Result[WIDTH-1];
    assign mag_in = neg_in ? (~Result + WIDTH'(1)) : Result;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            signed_result_decoder_adj u_adj (
                .digit_in  (scratch_q[g]),
                .digit_out (adj[g])
            );
        end
    endgenerate

    assign shifted = {adj, mag_q} << 1;
    assign Busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = CONV;
            CONV:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            sign_pend_q <= 1'b0;
            Sign        <= 1'b0;
            Hundreds    <= 4'd0;
            Tens        <= 4'd0;
            Ones        <= 4'd0;
            Done        <= 1'b0;
        end else begin
            state_q <= state_d;
            Done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    scratch_q <= '0;
                    cnt_q     <= '0;
                    if (Start) begin
                        mag_q       <= mag_in;
                        sign_pend_q <= neg_in;
                    end
                end
                CONV: begin
                    {scratch_q, mag_q} <= shifted;
                    cnt_q              <= cnt_q + CNT_W'(1);
                end
                FINISH: begin
                    // The displayed digits change only here, so partial
                    // scratch values never reach the outputs.
                    Sign     <= sign_pend_q;
                    Hundreds <= scratch_q[2];
                    Tens     <= scratch_q[1];
                    Ones     <= scratch_q[0];
                    Done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_result_decoder.sv
module tb_signed_result_decoder;
    logic       Clk;
    logic       Rst;
    logic       Start;
    logic       Signed_Mode;
    logic [7:0] Result;
    logic       Sign;
    logic [3:0] Hundreds, Tens, Ones;
    logic       Busy, Done;

    int errors = 0;
    int checks = 0;

    signed_result_decoder #(.WIDTH(8)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .Signed_Mode (Signed_Mode),
        .Result      (Result),
        .Sign        (Sign),
        .Hundreds    (Hundreds),
        .Tens        (Tens),
        .Ones        (Ones),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the value as a signed or unsigned integer, then decimal digits.
    task automatic ref_decode(input logic sm, input logic [7:0] r,
                              output logic s, output int h, output int t, output int o);
        int v;
        v = (sm && r >= 8'd128) ? int'(r) - 256 : int'(r);
        s = (v < 0);
        if (v < 0) v = -v;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
    endtask

    task automatic chk_out(input string tag, input logic s, input int h, input int t, input int o);
        chk($sformatf("%s sign", tag), 32'(Sign), 32'(s));
        chk($sformatf("%s hund", tag), 32'(Hundreds), h);
        chk($sformatf("%s tens", tag), 32'(Tens), t);
        chk($sformatf("%s ones", tag), 32'(Ones), o);
    endtask

    // Called at a negedge; presents a one-cycle Start. Returns at a negedge.
    task automatic run_one(input logic sm, input logic [7:0] r, input string tag);
        logic es;
        int eh, et, eo, lat, bc;
        ref_decode(sm, r, es, eh, et, eo);
        Start = 1'b1; Signed_Mode = sm; Result = r;
        @(negedge Clk);
        Start = 1'b0; Result = 8'($urandom); Signed_Mode = 1'($urandom);
        lat = 0; bc = 0;
        while (Done !== 1'b1 && lat < 20) begin
            if (Busy === 1'b1) bc++;
            @(negedge Clk);
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, 9);
        chk($sformatf("%s busy_cycles", tag), bc, 9);
        chk($sformatf("%s busy_at_done", tag), 32'(Busy), 0);
        chk_out(tag, es, eh, et, eo);
        @(negedge Clk);
        chk($sformatf("%s done_pulse", tag), 32'(Done), 0);
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        repeat (n) begin
            if (Done === 1'b1) c++;
            @(negedge Clk);
        end
    endtask

    initial begin
        int c, gap;
        logic [7:0] vals [2];
        Rst = 1'b0; Start = 1'b0; Signed_Mode = 1'b0; Result = 8'h00;
        #2 Rst = 1'b1;
        repeat (2) @(negedge Clk);
        chk_out("reset", 1'b0, 0, 0, 0);
        chk("reset busy", 32'(Busy), 0);
        chk("reset done", 32'(Done), 0);

        // Start presented right as reset drops: accepted on the first edge.
        Rst = 1'b0;
        run_one(1'b1, 8'h2D, "s_2d");
        run_one(1'b1, 8'h80, "s_80");
        run_one(1'b1, 8'hFF, "s_ff");
        run_one(1'b1, 8'h7F, "s_7f");
        run_one(1'b0, 8'hFF, "u_ff");
        run_one(1'b0, 8'h00, "u_00");

        // A second Start during Busy is dropped, not queued.
        Start = 1'b1; Signed_Mode = 1'b0; Result = 8'h05;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Start = 1'b1; Result = 8'h63;
        @(negedge Clk);
        Start = 1'b0;
        count_done(20, c);
        chk("ignore done_count", c, 1);
        chk("ignore busy", 32'(Busy), 0);
        chk_out("ignore", 1'b0, 0, 0, 5);

        run_one(1'b1, 8'h80, "pre_rst");

        // Reset mid-conversion aborts it without a Done.
        Start = 1'b1; Signed_Mode = 1'b1; Result = 8'h63;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk_out("abort", 1'b0, 0, 0, 0);
        chk("abort busy", 32'(Busy), 0);
        chk("abort done", 32'(Done), 0);
        @(negedge Clk);
        Rst = 1'b0;
        count_done(12, c);
        chk("abort done_count", c, 0);
        run_one(1'b1, 8'h63, "after_rst");

        // Start held high: one conversion every 10 clocks.
        vals[0] = 8'h0A; vals[1] = 8'hF6;
        Start = 1'b1; Signed_Mode = 1'b1; Result = vals[0];
        for (int i = 0; i < 4; i++) begin
            logic es;
            int eh, et, eo;
            ref_decode(1'b1, vals[i % 2], es, eh, et, eo);
            gap = 0;
            do begin
                @(negedge Clk);
                gap++;
            end while (Done !== 1'b1 && gap < 30);
            chk($sformatf("b2b%0d gap", i), gap, 10);
            chk_out($sformatf("b2b%0d", i), es, eh, et, eo);
            Result = vals[(i + 1) % 2];
        end
        Start = 1'b0;
        c = 0;
        while (Busy === 1'b1 && c < 20) begin
            @(negedge Clk);
            c++;
        end
        chk("b2b drained", 32'(Busy), 0);
        @(negedge Clk);

        for (int i = 0; i < 24; i++)
            run_one(1'($urandom), 8'($urandom), $sformatf("rand%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
